// File: rtl/boot_pump_pkg.sv
// Shared constants, host handshake states and byte-lane selection for bootdata_byte_pump.
package boot_pump_pkg;

  localparam logic [7:0] HDR_MAGIC = 8'h4E;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } host_state_e;

  // Byte index 0 is the most significant byte of the word.
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] lane;
    case (idx)
      2'd0:    lane = word[31:24];
      2'd1:    lane = word[23:16];
      2'd2:    lane = word[15:8];
      default: lane = word[7:0];
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock first-word-fall-through FIFO; a push while full is ignored even if a pop is present.
module sync_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/bootdata_byte_pump.sv
// Bridges the 4-phase boot-data word handshake to the paced byte interface of the game loader,
// trimming to rom_size and discarding bytes until the iNES header magic is seen.
module bootdata_byte_pump
  import boot_pump_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int BYTE_PERIOD = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rom_size,
  input  logic [31:0] bootdata,
  input  logic        bootdata_req,
  output logic        bootdata_ack,
  output logic [7:0]  loader_data,
  output logic        loader_strobe,
  output logic [31:0] bytes_consumed,
  output logic        done,
  output host_state_e dbg_host_state
);

  localparam int          PW          = (BYTE_PERIOD > 1) ? $clog2(BYTE_PERIOD) : 1;
  localparam logic [PW-1:0] PACE_RELOAD = PW'(BYTE_PERIOD - 1);

  host_state_e   host_state_q, host_state_d;
  logic [31:0]   words_in_q, words_in_d;
  logic [31:0]   word_q, word_d;
  logic [1:0]    idx_q, idx_d;
  logic          has_word_q, has_word_d;
  logic          synced_q, synced_d;
  logic [PW-1:0] pace_q, pace_d;
  logic [7:0]    loader_data_q, loader_data_d;
  logic          loader_strobe_q, loader_strobe_d;
  logic [31:0]   bytes_consumed_q, bytes_consumed_d;
  logic          done_q, done_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]   fifo_dout;
  logic          discard;
  logic [7:0]    cur_byte;
  logic          in_range, pending, is_magic, emit, drop, consume;
  logic          last_of_word, word_free;

  sync_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bootdata),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Host handshake: bootdata is valid while bootdata_req is high and must stay stable until
  // bootdata_ack pulses; ack is a single-cycle pulse, after which req must drop and be seen low
  // before the next word is taken, so one req-high phase never receives two acks.
  assign discard = ({words_in_q, 2'b00} >= {2'b00, rom_size});

  always_comb begin
    host_state_d = host_state_q;
    words_in_d   = words_in_q;
    fifo_push    = 1'b0;
    bootdata_ack = 1'b0;
    case (host_state_q)
      IDLE: begin
        if (bootdata_req && (!fifo_full || discard)) begin
          host_state_d = ACK;
        end
      end
      ACK: begin
        bootdata_ack = 1'b1;
        fifo_push    = !discard;
        words_in_d   = words_in_q + 32'd1;
        host_state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!bootdata_req) begin
          host_state_d = IDLE;
        end
      end
      default: host_state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_byte     = byte_lane(word_q, idx_q);
    in_range     = (bytes_consumed_q < rom_size);
    pending      = has_word_q && in_range;
    is_magic     = (cur_byte == HDR_MAGIC);
    emit         = pending && (synced_q || is_magic) && (pace_q == '0);
    drop         = pending && !synced_q && !is_magic;
    consume      = emit || drop;
    // Releasing the word on the final needed byte lets done rise one cycle after it.
    last_of_word = (idx_q == 2'd3) ||
                   (({1'b0, bytes_consumed_q} + 33'd1) >= {1'b0, rom_size});
    word_free    = !has_word_q || (consume && last_of_word) || (has_word_q && !in_range);
    fifo_pop     = word_free && !fifo_empty;

    has_word_d       = has_word_q;
    word_d           = word_q;
    idx_d            = idx_q;
    bytes_consumed_d = bytes_consumed_q;
    synced_d         = synced_q || emit;
    loader_strobe_d  = emit;
    loader_data_d    = emit ? cur_byte : loader_data_q;
    pace_d           = pace_q;

    if (consume) begin
      idx_d            = idx_q + 2'd1;
      bytes_consumed_d = bytes_consumed_q + 32'd1;
    end
    if (word_free) begin
      has_word_d = 1'b0;
    end
    if (fifo_pop) begin
      has_word_d = 1'b1;
      word_d     = fifo_dout;
      idx_d      = 2'd0;
    end

    if (emit) begin
      pace_d = PACE_RELOAD;
    end else if (pace_q != '0) begin
      pace_d = pace_q - PW'(1);
    end

    done_d = done_q || (!in_range && fifo_empty && !has_word_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      host_state_q     <= IDLE;
      words_in_q       <= '0;
      word_q           <= '0;
      idx_q            <= '0;
      has_word_q       <= 1'b0;
      synced_q         <= 1'b0;
      pace_q           <= '0;
      loader_data_q    <= '0;
      loader_strobe_q  <= 1'b0;
      bytes_consumed_q <= '0;
      done_q           <= 1'b0;
    end else begin
      host_state_q     <= host_state_d;
      words_in_q       <= words_in_d;
      word_q           <= word_d;
      idx_q            <= idx_d;
      has_word_q       <= has_word_d;
      synced_q         <= synced_d;
      pace_q           <= pace_d;
      loader_data_q    <= loader_data_d;
      loader_strobe_q  <= loader_strobe_d;
      bytes_consumed_q <= bytes_consumed_d;
      done_q           <= done_d;
    end
  end

  assign loader_data    = loader_data_q;
  assign loader_strobe  = loader_strobe_q;
  assign bytes_consumed = bytes_consumed_q;
  assign done           = done_q;
  assign dbg_host_state = host_state_q;

endmodule

// File: tb/tb_bootdata_byte_pump.sv
// Self-checking bench for bootdata_byte_pump: host driver process, strobe monitor with an
// expected-byte queue built from a stream-level model, and one task per scenario.
module tb_bootdata_byte_pump;
  import boot_pump_pkg::*;

  localparam int PERIOD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rom_size = 32'd8;
  logic [31:0] bootdata;
  logic        bootdata_req;
  logic        bootdata_ack;
  logic [7:0]  loader_data;
  logic        loader_strobe;
  logic [31:0] bytes_consumed;
  logic        done;
  host_state_e dbg_state;

  bootdata_byte_pump #(
    .FIFO_DEPTH  (2),
    .BYTE_PERIOD (PERIOD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rom_size       (rom_size),
    .bootdata       (bootdata),
    .bootdata_req   (bootdata_req),
    .bootdata_ack   (bootdata_ack),
    .loader_data    (loader_data),
    .loader_strobe  (loader_strobe),
    .bytes_consumed (bytes_consumed),
    .done           (done),
    .dbg_host_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Scoreboard and monitor state
  logic [7:0]  exp_q[$];
  logic [31:0] host_q[$];
  int          ack_count = 0;
  int          strobe_count = 0;
  int          max_ahead = 0;
  int          ahead;
  int          last_strobe_cyc = 0;
  int          done_cyc = 0;
  int          gap;
  bit          done_seen = 0;
  bit          acked_this_req = 0;
  bit          exact_gap = 0;
  bit          host_abort = 0;
  bit          host_hold = 0;
  int          h_phase = 0;
  logic [7:0]  exp_byte;
  int          model_strobes;
  logic [7:0]  model_last;
  logic [31:0] model_consumed;

  // Host driver: 4-phase handshake, one idle-low cycle between words
  initial begin
    bootdata_req = 1'b0;
    bootdata     = '0;
    forever begin
      @(posedge clk);
      #1;
      if (host_abort) begin
        host_q.delete();
        bootdata_req = 1'b0;
        h_phase      = 0;
        host_abort   = 0;
      end else begin
        case (h_phase)
          0: if (host_q.size() > 0) begin
               bootdata     = host_q[0];
               bootdata_req = 1'b1;
               h_phase      = 1;
             end
          1: if (bootdata_ack) begin
               void'(host_q.pop_front());
               if (host_hold) h_phase = 3;
               else begin
                 bootdata_req = 1'b0;
                 h_phase      = 2;
               end
             end
          2: h_phase = 0;
          default: if (!host_hold) begin
               bootdata_req = 1'b0;
               h_phase      = 2;
             end
        endcase
      end
    end
  end

  // Monitor: strobes against the expected queue, pacing, ack uniqueness per req-high phase
  always @(negedge clk) begin
    if (reset) begin
      acked_this_req = 0;
    end else begin
      if (bootdata_ack) begin
        n_cmp++;
        if (acked_this_req) begin
          n_bad++;
          $display("FAIL double_ack: second ack at cycle %0d within one req-high phase, expected none", cyc);
        end
        acked_this_req = 1;
        ack_count++;
      end else if (!bootdata_req) begin
        acked_this_req = 0;
      end
      if (loader_strobe) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_strobe: data=%h at cycle %0d, expected no strobe", loader_data, cyc);
        end else begin
          exp_byte = exp_q.pop_front();
          if (loader_data !== exp_byte) begin
            n_bad++;
            $display("FAIL strobe_data: got %h expected %h (strobe %0d)", loader_data, exp_byte, strobe_count);
          end
        end
        if (strobe_count > 0) begin
          gap = cyc - last_strobe_cyc;
          n_cmp++;
          if (exact_gap ? (gap != PERIOD) : (gap < PERIOD)) begin
            n_bad++;
            $display("FAIL strobe_gap: got %0d cycles, expected %s%0d", gap, exact_gap ? "" : ">=", PERIOD);
          end
        end
        last_strobe_cyc = cyc;
        strobe_count++;
      end
      ahead = ack_count - strobe_count / 4;
      if (ahead > max_ahead) max_ahead = ahead;
      if (done === 1'b1 && !done_seen) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
    end
  end

  // Stream-level model: trim to rom_size, drop until the magic byte, emit the rest
  task automatic model_load(input logic [31:0] rom, input logic [31:0] words[$]);
    bit synced = 0;
    int n = words.size() * 4;
    int lim = (int'(rom) < n) ? int'(rom) : n;
    logic [31:0] w;
    logic [7:0] b;
    model_strobes = 0;
    model_last    = 8'h00;
    for (int i = 0; i < lim; i++) begin
      w = words[i / 4];
      b = 8'(w >> (8 * (3 - (i % 4))));
      if (b == 8'h4E) synced = 1;
      if (synced) begin
        exp_q.push_back(b);
        model_strobes++;
        model_last = b;
      end
    end
    model_consumed = 32'(lim);
  endtask

  task automatic start_load(input logic [31:0] rom);
    @(posedge clk);
    #1;
    host_abort = 1;
    host_hold  = 0;
    reset      = 1'b1;
    rom_size   = rom;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    ack_count    = 0;
    strobe_count = 0;
    max_ahead    = 0;
    done_seen    = 0;
    exact_gap    = 0;
    reset        = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int t = 0;
    while (!(done === 1'b1 && host_q.size() == 0 && h_phase == 0) && t < limit) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= limit) begin
      n_bad++;
      $display("FAIL %s_timeout: done=%b words_left=%0d, expected done within %0d cycles",
               name, done, host_q.size(), limit);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_end(input string name, input int nwords);
    n_cmp++;
    if (bytes_consumed !== model_consumed) begin
      n_bad++;
      $display("FAIL %s_bytes_consumed: got %0d expected %0d", name, bytes_consumed, model_consumed);
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_done: got %b expected 1", name, done);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_missing_bytes: got %0d bytes never strobed, expected 0", name, exp_q.size());
    end
    n_cmp++;
    if (strobe_count != model_strobes) begin
      n_bad++;
      $display("FAIL %s_strobe_count: got %0d expected %0d", name, strobe_count, model_strobes);
    end
    n_cmp++;
    if (loader_data !== model_last) begin
      n_bad++;
      $display("FAIL %s_data_hold: got %h expected %h", name, loader_data, model_last);
    end
    n_cmp++;
    if (ack_count != nwords) begin
      n_bad++;
      $display("FAIL %s_ack_count: got %0d expected %0d", name, ack_count, nwords);
    end
    if (model_strobes > 0) begin
      n_cmp++;
      if (done_cyc - last_strobe_cyc != 1) begin
        n_bad++;
        $display("FAIL %s_done_latency: got %0d cycles after last strobe, expected 1",
                 name, done_cyc - last_strobe_cyc);
      end
    end
  endtask

  task automatic run_load(input string name, input logic [31:0] rom, input logic [31:0] words[$],
                          input bit exact);
    start_load(rom);
    exact_gap = exact;
    model_load(rom, words);
    foreach (words[i]) host_q.push_back(words[i]);
    wait_done(3000, name);
    check_end(name, words.size());
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bootdata_ack, loader_strobe, done} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: ack/strobe/done got %b expected 000", {bootdata_ack, loader_strobe, done});
    end
    n_cmp++;
    if (loader_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_data: got %h expected 00", loader_data);
    end
    n_cmp++;
    if (bytes_consumed !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_bytes: got %0d expected 0", bytes_consumed);
    end
    n_cmp++;
    if (dbg_state !== IDLE) begin
      n_bad++;
      $display("FAIL reset_state: got %0d expected IDLE", dbg_state);
    end
  endtask

  task automatic test_header_stream();
    logic [31:0] w[$];
    w = '{32'h4E45531A, 32'h01020304};
    run_load("hdr", 32'd8, w, 1'b1);
    n_cmp++;
    if (strobe_count != 8) begin
      n_bad++;
      $display("FAIL hdr_strobes: got %0d expected 8", strobe_count);
    end
  endtask

  task automatic test_presync_drop();
    logic [31:0] w[$];
    w = '{32'h00FF4E45};
    run_load("presync", 32'd4, w, 1'b1);
    n_cmp++;
    if (strobe_count != 2) begin
      n_bad++;
      $display("FAIL presync_strobes: got %0d expected 2", strobe_count);
    end
  endtask

  task automatic test_trim();
    logic [31:0] w[$];
    w = '{32'h4E010203, 32'h04050607, 32'h08090A0B};
    run_load("trim", 32'd6, w, 1'b1);
    n_cmp++;
    if (bytes_consumed !== 32'd6) begin
      n_bad++;
      $display("FAIL trim_consumed: got %0d expected 6", bytes_consumed);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[$];
    w.push_back({8'h4E, 24'($urandom)});
    for (int i = 1; i < 10; i++) w.push_back($urandom);
    run_load("b2b", 32'd40, w, 1'b1);
    n_cmp++;
    if (max_ahead != 3) begin
      n_bad++;
      $display("FAIL b2b_words_ahead: got max %0d expected 3", max_ahead);
    end
  endtask

  task automatic test_req_held();
    start_load(32'd4);
    exact_gap = 1;
    host_hold = 1;
    model_load(32'd4, '{32'h4E112233});
    host_q.push_back(32'h4E112233);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (ack_count != 1) begin
      n_bad++;
      $display("FAIL held_req_acks: got %0d expected 1", ack_count);
    end
    host_hold = 0;
    wait_done(500, "held");
    check_end("held", 1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] w[$];
    int t = 0;
    w = '{32'h4E45531A, 32'h01020304};
    start_load(32'd8);
    model_load(32'd8, w);
    foreach (w[i]) host_q.push_back(w[i]);
    while (strobe_count < 2 && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (strobe_count < 2) begin
      n_bad++;
      $display("FAIL midreset_progress: got %0d strobes expected 2 before reset", strobe_count);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    host_abort = 1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bootdata_ack, loader_strobe, done, loader_data, bytes_consumed} !== 43'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs: ack=%b strobe=%b done=%b data=%h bytes=%0d expected all zero",
               bootdata_ack, loader_strobe, done, loader_data, bytes_consumed);
    end
    run_load("reload", 32'd8, w, 1'b1);
  endtask

  task automatic test_rom_zero();
    logic [31:0] w[$];
    start_load(32'd0);
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_done_early: got %b expected 1 one cycle after reset", done);
    end
    w = '{32'h4E000000, 32'h11223344, 32'h55667788};
    model_load(32'd0, w);
    foreach (w[i]) host_q.push_back(w[i]);
    wait_done(500, "zero");
    check_end("zero", 3);
  endtask

  task automatic test_random();
    logic [31:0] w[$];
    logic [31:0] tmp;
    int n, pos;
    logic [31:0] rom;
    for (int it = 0; it < 6; it++) begin
      w.delete();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) w.push_back($urandom);
      pos = $urandom_range(0, 4 * n - 1);
      tmp = w[pos / 4];
      tmp[8 * (3 - (pos % 4)) +: 8] = 8'h4E;
      w[pos / 4] = tmp;
      rom = 32'($urandom_range(1, 4 * n));
      run_load("rand", rom, w, 1'b0);
    end
  endtask

  initial begin
    #500000;
    n_bad++;
    $display("FAIL global_timeout: simulation did not complete, expected finish before 50000 cycles");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    test_reset();
    test_header_stream();
    test_presync_drop();
    test_trim();
    test_back_to_back();
    test_req_held();
    test_reset_mid();
    test_rom_zero();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
